// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM encoding and counter width for the data-memory responder.
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request channel and valid/ready response channel.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores (enables + merged word) and extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] lword,
    output logic        misalign
);
    logic [15:0] sh;
    logic [31:0] rep, mask;
    always_comb begin
        sh = 16'(word >> {addr_lo, 3'b000});
        rep = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        be = funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo
           : funct3[1:0] == 2'b01 ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wword = (rep & mask) | (word & ~mask);
        misalign = funct3[1:0] == 2'b01 ? addr_lo[0] : funct3[1:0] == 2'b10 ? |addr_lo : 1'b0;
        lword = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]}
              : funct3 == F3_H  ? {{16{sh[15]}}, sh}
              : funct3 == F3_BU ? {24'b0, sh[7:0]}
              : funct3 == F3_HU ? {16'b0, sh} : word;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data memory answering one load/store at a time after WAIT_STATES wait cycles.
// The array is written and the load data registered on the edge that enters RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q, wdata_q;
    logic [31:0]      mem [DEPTH_WORDS];
    logic             op_we;
    logic [2:0]       op_f3;
    logic [31:0]      op_addr, op_wdata;
    logic [32:0]      off;
    logic [AW-1:0]    idx;
    logic [3:0]       be;
    logic [31:0]      wword, lword;
    logic             misalign, illegal, err, commit;
    // With zero wait states the commit edge is the acceptance edge, so use the live request.
    always_comb begin
        op_we = state == ST_IDLE ? bus.req_we : we_q;
        op_f3 = state == ST_IDLE ? bus.req_funct3 : f3_q;
        op_addr = state == ST_IDLE ? bus.req_addr : addr_q;
        op_wdata = state == ST_IDLE ? bus.req_wdata : wdata_q;
        off = {1'b0, op_addr} - {1'b0, BASE_ADDR};
        idx = off[AW+1:2];
        illegal = op_f3 == 3'b011 || op_f3[2:1] == 2'b11 || (op_we && op_f3[2]);
        err = illegal || misalign || off >= 33'(4 * DEPTH_WORDS);
        commit = state == ST_IDLE ? bus.req_valid && WAIT_STATES == 0 : state == ST_WAIT && cnt == '0;
    end
    assign bus.req_ready = state == ST_IDLE && !reset;
    dmem_lane_align u_align (
        .funct3  (op_f3),
        .addr_lo (op_addr[1:0]),
        .word    (mem[idx]),
        .wdata   (op_wdata),
        .be      (be),
        .wword   (wword),
        .lword   (lword),
        .misalign(misalign)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= '0;
            we_q <= 1'b0;
            f3_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    we_q <= bus.req_we;
                    f3_q <= bus.req_funct3;
                    addr_q <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    cnt <= CNT_W'(WAIT_STATES - 1);
                    state <= commit ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (commit) state <= ST_RESP;
                end
                ST_RESP: if (bus.rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (commit) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_rdata <= err || op_we ? '0 : lword;
                bus.rsp_err <= err;
            end else if (state == ST_RESP && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
                bus.rsp_rdata <= '0;
                bus.rsp_err <= 1'b0;
            end
        end
    end
    // Storage is deliberately not reset; a store cut off by reset never reaches this edge.
    always_ff @(posedge clk) begin
        if (commit && !reset && op_we && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i+:8] <= wword[8*i+:8];
    end
endmodule
